mempak_block: RTL and testbench

- Block-transfer engine for controller-pak memory emulation.
- Holds NUM_BANKS independent 32 KiB paks, one 16-bit single-port RAM per bank.
- Moves one 32-byte pak block per command as a byte stream, big-endian, high byte of each halfword first.
- Computes the N64 8-bit data CRC over each block. Sits between the joybus command decoder and the RAM primitives.

---
 rtl/mempak_pkg.sv | 31 +++
 rtl/mempak_spram_bank.sv | 20 ++
 rtl/mempak_block.sv | 152 +++++++++++++++
 tb/tb_mempak_block.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mempak_pkg.sv
// rtl/mempak_pkg.sv - shared constants, state encoding and CRC step for the mempak block engine
package mempak_pkg;

    localparam int BLOCK_BYTES          = 32;
    localparam int HALFWORDS_PER_BLOCK  = 16;
    localparam logic [7:0] CRC_POLY     = 8'h85;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_FETCH,
        S_RD_STREAM,
        S_WR_STREAM,
        S_WR_COMMIT,
        S_FINISH
    } state_t;

    // Augmented (shift-in) CRC: the message bits enter at the LSB, so a zero
    // flush byte is needed at the end to push the last data bits through.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        logic       tap;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            tap = c[7];
            c   = {c[6:0], data[i]};
            if (tap) c = c ^ CRC_POLY;
        end
        return c;
    endfunction

endpackage

// File: rtl/mempak_spram_bank.sv
// rtl/mempak_spram_bank.sv - one 16K x 16 single-port RAM holding a 32 KiB pak
module mempak_spram_bank (
    input  logic        clk,
    input  logic        en,
    input  logic        we,
    input  logic [13:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata
);

    logic [15:0] mem [16384];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/mempak_block.sv
// rtl/mempak_block.sv - 32-byte block read/write engine with N64 data CRC over banked pak RAMs
module mempak_block
    import mempak_pkg::*;
#(
    parameter int         NUM_BANKS     = 1,
    parameter int         BLOCK_BYTES   = mempak_pkg::BLOCK_BYTES,
    parameter logic [7:0] UNMAPPED_FILL = 8'h00,
    localparam int        BANK_W        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [BANK_W-1:0] cmd_bank,
    input  logic [15:0]       cmd_addr,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    input  logic [7:0]        wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              done,
    output logic [7:0]        crc
);

    state_t            state, state_nxt;
    logic [BANK_W-1:0] bank_r;
    logic [9:0]        blk_r;
    logic              mapped_r;
    logic [4:0]        byte_cnt;
    logic [7:0]        hi_buf, lo_buf;
    logic [15:0]       wr_hw;
    logic [7:0]        crc_acc, crc_q, crc_flush;
    logic              ram_rd, ram_wr;
    logic [3:0]        ram_k;
    logic [15:0]       bank_q [NUM_BANKS];
    logic [15:0]       sel_q, src_hw;
    logic              unused_addr_lsbs;

    wire cmd_fire = cmd_valid && cmd_ready;
    wire rd_fire  = rd_valid && rd_ready;
    wire wr_fire  = wr_valid && wr_ready;
    wire last_byte = (byte_cnt == 5'(BLOCK_BYTES - 1));

    assign unused_addr_lsbs = ^cmd_addr[4:0];
    assign crc_flush = crc8_step(crc_acc, 8'h00);
    assign crc       = (state == S_FINISH) ? crc_flush : crc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (cmd_fire) state_nxt = cmd_write ? S_WR_STREAM : S_RD_FETCH;
            S_RD_FETCH:  state_nxt = S_RD_STREAM;
            S_RD_STREAM: if (rd_fire && last_byte) state_nxt = S_FINISH;
            S_WR_STREAM: if (wr_fire && byte_cnt[0]) state_nxt = S_WR_COMMIT;
            S_WR_COMMIT: state_nxt = (byte_cnt == 5'd0) ? S_FINISH : S_WR_STREAM;
            S_FINISH:    state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // The next halfword is fetched as its predecessor's high byte leaves, so
    // the RAM output is ready by the time the low byte is taken.
    always_comb begin
        cmd_ready = (state == S_IDLE);
        wr_ready  = (state == S_WR_STREAM);
        done      = (state == S_FINISH);
        ram_rd    = mapped_r && ((state == S_RD_FETCH) ||
                    (state == S_RD_STREAM && rd_fire && !byte_cnt[0] && byte_cnt[4:1] != 4'hF));
        ram_wr    = mapped_r && (state == S_WR_COMMIT);
        case (state)
            S_RD_FETCH:  ram_k = 4'd0;
            S_RD_STREAM: ram_k = byte_cnt[4:1] + 4'd1;
            default:     ram_k = byte_cnt[4:1] - 4'd1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_r   <= '0;
            blk_r    <= '0;
            mapped_r <= 1'b0;
            byte_cnt <= '0;
            hi_buf   <= '0;
            lo_buf   <= '0;
            wr_hw    <= '0;
            crc_acc  <= '0;
            crc_q    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (cmd_fire) begin
                bank_r   <= cmd_bank;
                blk_r    <= cmd_addr[14:5];
                mapped_r <= !cmd_addr[15] && (32'(cmd_bank) < 32'(NUM_BANKS));
                byte_cnt <= '0;
                crc_acc  <= '0;
            end
            if (state == S_RD_STREAM) begin
                if (!rd_valid) begin
                    rd_data  <= src_hw[15:8];
                    lo_buf   <= src_hw[7:0];
                    rd_valid <= 1'b1;
                end else if (rd_fire) begin
                    crc_acc  <= crc8_step(crc_acc, rd_data);
                    byte_cnt <= byte_cnt + 5'd1;
                    if (!byte_cnt[0]) begin
                        rd_data <= lo_buf;
                    end else if (last_byte) begin
                        rd_valid <= 1'b0;
                    end else begin
                        rd_data <= src_hw[15:8];
                        lo_buf  <= src_hw[7:0];
                    end
                end
            end
            if (state == S_WR_STREAM && wr_fire) begin
                crc_acc  <= crc8_step(crc_acc, wr_data);
                byte_cnt <= byte_cnt + 5'd1;
                if (!byte_cnt[0]) hi_buf <= wr_data;
                else              wr_hw  <= {hi_buf, wr_data};
            end
            if (state == S_FINISH) crc_q <= crc_flush;
        end
    end

    always_comb begin
        sel_q = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            if (bank_r == BANK_W'(b)) sel_q = bank_q[b];
    end

    assign src_hw = mapped_r ? sel_q : {UNMAPPED_FILL, UNMAPPED_FILL};

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        mempak_spram_bank u_ram (
            .clk   (clk),
            .en    ((ram_rd || ram_wr) && (bank_r == BANK_W'(g))),
            .we    (ram_wr),
            .addr  ({blk_r, ram_k}),
            .wdata (wr_hw),
            .rdata (bank_q[g])
        );
    end

endmodule

// File: tb/tb_mempak_block.sv
// tb/tb_mempak_block.sv - directed scoreboard bench for mempak_block with two banks
module tb_mempak_block;

    typedef logic [7:0] blk_t [32];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [0:0]  cmd_bank = '0;
    logic [15:0] cmd_addr = '0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        done;
    logic [7:0]  crc;

    int vec = 0;
    int errs = 0;
    int cyc = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mempak_block #(.NUM_BANKS(2), .UNMAPPED_FILL(8'h00)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_bank(cmd_bank), .cmd_addr(cmd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .done(done), .crc(crc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vec++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, expv);
        end
    endtask

    // Long division of (32 data bytes ++ 0x00) by x^8+x^7+x^2+1.
    function automatic logic [7:0] model_crc(input blk_t b);
        logic [8:0] r;
        logic [7:0] d;
        r = '0;
        for (int i = 0; i < 33; i++) begin
            d = (i < 32) ? b[i] : 8'h00;
            for (int j = 7; j >= 0; j--) begin
                r = {r[7:0], d[j]};
                if (r[8]) r[7:0] = r[7:0] ^ 8'h85;
                r[8] = 1'b0;
            end
        end
        return r[7:0];
    endfunction

    task automatic issue_cmd(input logic w, input logic bank, input logic [15:0] addr, output int t);
        int g;
        g = 0;
        @(negedge clk);
        while (!cmd_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = w; cmd_bank = bank; cmd_addr = addr;
        t = cyc;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic write_block(input logic bank, input logic [15:0] addr, input blk_t b,
                               input int abort_at, output logic [7:0] crc_o,
                               output int last_c, output int done_c);
        int i, g, t;
        issue_cmd(1'b1, bank, addr, t);
        i = 0; g = 0; last_c = -1; done_c = -1; crc_o = '0;
        while (i < 32 && g < 200) begin
            @(negedge clk);
            g++;
            wr_valid = 1'b1;
            wr_data  = b[i];
            if (wr_ready) begin
                last_c = cyc;
                @(posedge clk);
                #1;
                i++;
                wr_valid = 1'b0;
                if (i == abort_at) begin
                    reset = 1'b1;
                    break;
                end
            end
        end
        wr_valid = 1'b0;
        if (abort_at > 0) begin
            repeat (2) @(negedge clk);
            check("wr_ready_in_reset", wr_ready, 0);
            reset = 1'b0;
            @(negedge clk);
            check("cmd_ready_after_reset", cmd_ready, 1);
        end else begin
            g = 0;
            while (!done && g < 20) begin
                @(negedge clk);
                g++;
            end
            if (done) begin
                done_c = cyc;
                crc_o  = crc;
            end
            check("wr_count", i, 32);
            check("wr_done_seen", done, 1);
        end
    endtask

    task automatic read_block(input logic bank, input logic [15:0] addr, input blk_t expb,
                              input int stall_at, output logic [7:0] crc_o,
                              output int t_acc, output int first_c, output int done_c);
        int n, guard, dones;
        bit stalled;
        for (int i = 0; i < 32; i++) exp_q.push_back(expb[i]);
        rd_ready = 1'b1;
        issue_cmd(1'b0, bank, addr, t_acc);
        n = 0; guard = 0; dones = 0; stalled = 0;
        first_c = -1; done_c = -1; crc_o = '0;
        while (dones == 0 && guard < 300) begin
            @(negedge clk);
            guard++;
            if (rd_valid) begin
                if (n == stall_at && !stalled) begin
                    stalled  = 1;
                    rd_ready = 1'b0;
                    repeat (5) begin
                        @(negedge clk);
                        check("stall_hold", rd_data, exp_q[0]);
                        check("stall_valid", rd_valid, 1);
                    end
                    rd_ready = 1'b1;
                end
                if (n == 0) first_c = cyc;
                check("rd_byte", rd_data, exp_q.pop_front());
                n++;
            end
            if (done) begin
                dones++;
                done_c = cyc;
                crc_o  = crc;
            end
        end
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("rd_count", n, 32);
        check("rd_done_once", dones, 1);
        exp_q.delete();
    endtask

    initial begin
        blk_t inc, zero, ones, a5, c0, mix;
        logic [7:0] crc_w, crc_r;
        int t, f, d, lc;

        for (int i = 0; i < 32; i++) begin
            inc[i]  = 8'(i);
            zero[i] = 8'h00;
            ones[i] = 8'hFF;
            a5[i]   = 8'hA5;
            c0[i]   = 8'(8'hC0 + i);
            mix[i]  = (i < 6) ? 8'(8'h60 + i) : 8'(8'hC0 + i);
        end

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_done", done, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_crc", crc, 0);
        reset = 1'b0;

        // incrementing block round trip
        write_block(1'b0, 16'h0020, inc, -1, crc_w, lc, d);
        check("wr_crc_inc", crc_w, model_crc(inc));
        check("wr_done_timing", d, lc + 2);
        @(negedge clk);
        check("crc_held", crc, crc_w);
        read_block(1'b0, 16'h0020, inc, -1, crc_r, t, f, d);
        check("rd_crc_inc", crc_r, model_crc(inc));
        check("rd_wr_crc_equal", crc_r, crc_w);

        // zero block and read timing
        write_block(1'b0, 16'h0040, zero, -1, crc_w, lc, d);
        check("wr_crc_zero", crc_w, 0);
        read_block(1'b0, 16'h0040, zero, -1, crc_r, t, f, d);
        check("rd_crc_zero", crc_r, 0);
        check("rd_first_valid", f, t + 3);
        check("rd_done_time", d, t + 35);

        // unmapped region
        read_block(1'b0, 16'h8000, zero, -1, crc_r, t, f, d);
        check("unmapped_crc", crc_r, 0);
        check("unmapped_done_time", d, t + 35);
        write_block(1'b0, 16'h8000, ones, -1, crc_w, lc, d);
        check("unmapped_wr_crc", crc_w, model_crc(ones));
        read_block(1'b0, 16'h0020, inc, -1, crc_r, t, f, d);

        // bank isolation and ignored low address bits
        write_block(1'b1, 16'h0020, a5, -1, crc_w, lc, d);
        check("bank1_wr_crc", crc_w, model_crc(a5));
        read_block(1'b0, 16'h0035, inc, -1, crc_r, t, f, d);
        check("alias_crc", crc_r, model_crc(inc));
        read_block(1'b1, 16'h0020, a5, -1, crc_r, t, f, d);
        check("bank1_rd_crc", crc_r, model_crc(a5));

        // backpressure on byte 9
        read_block(1'b0, 16'h0020, inc, 9, crc_r, t, f, d);
        check("stall_crc", crc_r, model_crc(inc));

        // reset in the middle of a write
        write_block(1'b0, 16'h0060, c0, -1, crc_w, lc, d);
        for (int i = 0; i < 32; i++) inc[i] = 8'(8'h60 + i);
        write_block(1'b0, 16'h0060, inc, 7, crc_w, lc, d);
        check("post_reset_crc", crc, 0);
        read_block(1'b0, 16'h0060, mix, -1, crc_r, t, f, d);
        check("partial_crc", crc_r, model_crc(mix));

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
